// File: rtl/bus_arb_driver_if.sv
// bus_arb_driver_if: requester-side request/data lanes and the shared tri-state bus with its ownership status.
interface bus_arb_driver_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int CW = $clog2(NCH);
    logic [NCH-1:0]       req;
    logic [NCH*WIDTH-1:0] data_in;
    wire  [WIDTH-1:0]     data_out;
    logic [NCH-1:0]       grant;
    logic                 bus_en;
    logic [CW-1:0]        owner;
    modport master (input req, data_in, output data_out, grant, bus_en, owner);
    modport slave  (output req, data_in, input data_out, grant, bus_en, owner);
endinterface

// File: rtl/bus_arb_driver.sv
// bus_arb_driver: round-robin owner of a shared tri-state bus with capped tenures
// and a one-cycle released turnaround between consecutive owners.
module bus_arb_driver #(
    parameter int WIDTH    = 8,
    parameter int NCH      = 4,
    parameter int MAX_HOLD = 4
) (
    input logic              clk,
    input logic              rst,
    bus_arb_driver_if.master bus
);
    localparam int CW = $clog2(NCH);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  owner_q, owner_n, ptr, ptr_n, pick;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [NCH-1:0] grant_q, grant_n;
    logic           bus_en_q, bus_en_n;

    // Rotating priority: first requester at or after ptr, wrapping.
    always_comb begin
        pick = ptr;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.req[(int'(ptr) + i) % NCH]) pick = CW'((int'(ptr) + i) % NCH);
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner_q;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        case (state)
            DRIVE: begin
                if (bus.req[owner_q] && hold_cnt < HW'(MAX_HOLD)) begin
                    hold_n = hold_cnt + 1'b1;
                end else begin
                    state_n = TURN;
                    ptr_n   = (owner_q == CW'(NCH - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_n = |bus.req ? DRIVE : IDLE;
                if (|bus.req) begin
                    owner_n = pick;
                    hold_n  = HW'(1);
                end
            end
        endcase
        bus_en_n = (state_n == DRIVE);
        grant_n  = bus_en_n ? NCH'(1) << owner_n : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner_q  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            grant_q  <= '0;
            bus_en_q <= 1'b0;
        end else begin
            state    <= state_n;
            owner_q  <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            grant_q  <= grant_n;
            bus_en_q <= bus_en_n;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.bus_en   = bus_en_q;
    assign bus.owner    = owner_q;
    assign bus.data_out = bus_en_q ? bus.data_in[owner_q*WIDTH +: WIDTH] : {WIDTH{1'bz}};
endmodule

// File: tb/tb_bus_arb_driver.sv
// tb_bus_arb_driver: directed vectors for the 8x4 hold-4 instance and a 16x2 hold-1 instance.
module tb_bus_arb_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bus_arb_driver_if #(.WIDTH(8),  .NCH(4)) b0 ();
    bus_arb_driver_if #(.WIDTH(16), .NCH(2)) b1 ();

    bus_arb_driver #(.WIDTH(8),  .NCH(4), .MAX_HOLD(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    bus_arb_driver #(.WIDTH(16), .NCH(2), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    logic [7:0]  dat0 [4] = '{8'h11, 8'h7B, 8'h33, 8'h44};
    logic [15:0] dat1 [2] = '{16'hA5C3, 16'h1234};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // grant==0 means released; otherwise also verify owner and driven data.
    task automatic chk0(input string tag, input logic [3:0] g, input int o);
        chk({tag, ".grant"}, 32'(b0.grant), 32'(g));
        chk({tag, ".bus_en"}, 32'(b0.bus_en), 32'(g != 0));
        if (g != 0) begin
            chk({tag, ".owner"}, 32'(b0.owner), 32'(o));
            chk({tag, ".data"}, 32'(b0.data_out), 32'(dat0[o]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b0.req = '0;
        b1.req = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        b0.data_in = {dat0[3], dat0[2], dat0[1], dat0[0]};
        b1.data_in = {dat1[1], dat1[0]};
        b0.req = 4'hF;
        b1.req = 2'b11;
        #1;
        chk0("t1.async", 4'b0000, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk0("t1.rst", 4'b0000, 0);
            chk("t1.owner", 32'(b0.owner), 0);
            chk("t1.b1grant", 32'(b1.grant), 0);
        end

        // single requester, two driven cycles then release
        rst = 1'b0;
        b0.req = 4'b0010;
        b1.req = '0;
        tick(); chk0("t2.c1", 4'b0010, 1);
        tick(); chk0("t2.c2", 4'b0010, 1);
        b0.req = '0;
        tick(); chk0("t2.turn", 4'b0000, 0);
        tick(); chk0("t2.idle", 4'b0000, 0);

        // full rotation with all requesting
        do_reset();
        b0.req = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int h = 0; h < 4; h++) begin
                tick(); chk0("t3.drive", 4'(1 << c), c);
            end
            tick(); chk0("t3.turn", 4'b0000, 0);
        end
        tick(); chk0("t3.wrap", 4'b0001, 0);

        // pointer past ch0 makes ch2 win over ch0
        do_reset();
        b0.req = 4'b0001;
        tick(); chk0("t4.ch0", 4'b0001, 0);
        b0.req = 4'b0100;
        tick(); chk0("t4.turn", 4'b0000, 0);
        b0.req = 4'b0101;
        for (int h = 0; h < 4; h++) begin
            tick(); chk0("t4.ch2", 4'b0100, 2);
        end
        tick(); chk0("t4.turn2", 4'b0000, 0);
        tick(); chk0("t4.ch0b", 4'b0001, 0);

        // async reset mid-tenure of ch3
        do_reset();
        b0.req = 4'b1000;
        tick(); chk0("t5.ch3", 4'b1000, 3);
        #1 rst = 1'b1;
        #1 chk0("t5.async", 4'b0000, 0);
        rst = 1'b0;
        b0.req = 4'b1001;
        tick(); chk0("t5.ch0", 4'b0001, 0);

        // 16-bit two-channel hold-1 alternation
        do_reset();
        b1.req = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 1) begin
                chk("t6.grant_z", 32'(b1.grant), 0);
                chk("t6.en_z", 32'(b1.bus_en), 0);
            end else begin
                chk("t6.grant", 32'(b1.grant), 32'(1 << ((k / 2) % 2)));
                chk("t6.en", 32'(b1.bus_en), 1);
                chk("t6.owner", 32'(b1.owner), 32'((k / 2) % 2));
                chk("t6.data", 32'(b1.data_out), 32'(dat1[(k / 2) % 2]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
